// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment driver for the game timer and score
// Frame-synchronous snapshot, leading-zero blanking, anti-ghost window, time-up blink.
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int BLINK_DIV      = 25,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] TIME_QL,
    input  logic [2:0] TIME_QH,
    input  logic       TIME_CA,
    input  logic [3:0] SCORE_L,
    input  logic [3:0] SCORE_H,
    input  logic       CLR_UP,
    output logic [7:0] SEG,
    output logic [3:0] AN,
    output logic       TIME_UP
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_V    = DW'(BLANK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV);
    localparam logic [7:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]    AN_OFF     = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [DW-1:0] div_cnt;
    logic [1:0]    ptr;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          time_up;
    logic          first_cyc;
    logic [3:0]    snap_ql;
    logic [2:0]    snap_qh;
    logic [3:0]    snap_sl;
    logic [3:0]    snap_sh;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    digit;
    logic          dp;
    logic          blank;
    logic [7:0]    seg_hi;
    logic [3:0]    an_hi;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (ptr == 2'd3);
    assign TIME_UP   = time_up;

    always_comb begin
        digit = snap_ql;
        dp    = 1'b0;
        blank = 1'b0;
        case (ptr)
            2'd0: begin
                digit = snap_ql;
                blank = !blink_on;
            end
            2'd1: begin
                digit = {1'b0, snap_qh};
                blank = (snap_qh == 3'd0) || !blink_on;
            end
            2'd2: begin
                digit = snap_sl;
                dp    = 1'b1;
            end
            default: begin
                digit = snap_sh;
                blank = (snap_sh == 4'd0);
            end
        endcase
        seg_hi = {dp, decode(digit)};
        // Anodes stay dark for the first BLANK_CYC cycles so the segment lines settle first.
        an_hi  = ((div_cnt >= BLANK_V) && !blank) ? (4'b0001 << ptr) : 4'b0000;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt   <= '0;
            ptr       <= 2'd0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            time_up   <= 1'b0;
            first_cyc <= 1'b1;
            snap_ql   <= 4'd0;
            snap_qh   <= 3'd0;
            snap_sl   <= 4'd0;
            snap_sh   <= 4'd0;
            SEG       <= SEG_OFF;
            AN        <= AN_OFF;
        end else begin
            div_cnt   <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end)
                ptr <= ptr + 2'd1;
            first_cyc <= 1'b0;
            if (first_cyc || frame_end) begin
                snap_ql <= TIME_QL;
                snap_qh <= TIME_QH;
                snap_sl <= SCORE_L;
                snap_sh <= SCORE_H;
            end
            time_up <= TIME_CA | (time_up & ~CLR_UP);
            // The count runs 1..BLINK_DIV after each toggle; starting from 0 makes the partial frame free.
            if (!time_up) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= BW'(1);
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            SEG <= seg_hi ^ {8{SEG_ACTIVE_LOW}};
            AN  <= an_hi ^ {4{SEG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] time_ql;
    logic [2:0] time_qh;
    logic       time_ca;
    logic [3:0] score_l;
    logic [3:0] score_h;
    logic       clr_up;
    logic [7:0] seg;
    logic [3:0] an;
    logic       time_up;

    int         checks = 0;
    int         errors = 0;
    int         lit[4];
    logic [7:0] seg_lit[4];
    logic [7:0] seg_end[4];
    int         overlap;
    int         first_lit;
    logic       tu_hist[32];
    logic [3:0] last_an;
    logic [7:0] last_seg;

    seg7_scan_driver #(
        .SCAN_DIV(8),
        .BLANK_CYC(2),
        .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(clk),
        .RESET(reset),
        .TIME_QL(time_ql),
        .TIME_QH(time_qh),
        .TIME_CA(time_ca),
        .SCORE_L(score_l),
        .SCORE_H(score_h),
        .CLR_UP(clr_up),
        .SEG(seg),
        .AN(an),
        .TIME_UP(time_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 1 QL->6, 2 TIME_CA pulse, 3 CLR_UP pulse, 4 both, 5 RESET pulse
    task automatic apply(input int kind, input logic on);
        case (kind)
            1: if (on) time_ql = 4'd6;
            2: time_ca = on;
            3: clr_up = on;
            4: begin time_ca = on; clr_up = on; end
            5: reset = on;
            default: ;
        endcase
    endtask

    task automatic run_frame(input int ev_i, input int kind, input int n);
        int s;
        logic [3:0] mask;
        for (int k = 0; k < 4; k++) begin
            lit[k] = 0;
            seg_lit[k] = 8'h00;
            seg_end[k] = 8'h00;
        end
        overlap = 0;
        first_lit = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            s = i / 8;
            mask = 4'b0001 << s;
            tu_hist[i] = time_up;
            last_an = an;
            last_seg = seg;
            if (an != 4'hF) begin
                if (first_lit < 0) first_lit = i;
                if (an[s] == 1'b0) begin
                    lit[s]++;
                    seg_lit[s] = seg;
                end
                if ((~an & ~mask) != 4'h0) overlap++;
            end
            seg_end[s] = seg;
            if (i == ev_i) apply(kind, 1'b1);
            if (i == ev_i + 1) apply(kind, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        time_ql = 4'd5;
        time_qh = 3'd2;
        score_l = 4'd7;
        score_h = 4'd0;
        time_ca = 1'b0;
        clr_up = 1'b0;
        repeat (3) tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_tu", 32'(time_up), 32'h0);
        reset = 1'b0;

        run_frame(-1, 0, 32);
        check("f0_first_lit", 32'(first_lit), 32'd2);
        check("f0_lit0", 32'(lit[0]), 32'd6);
        check("f0_seg0", 32'(seg_lit[0]), 32'h92);
        check("f0_lit1", 32'(lit[1]), 32'd6);
        check("f0_seg1", 32'(seg_lit[1]), 32'hA4);
        check("f0_lit2", 32'(lit[2]), 32'd6);
        check("f0_seg2", 32'(seg_lit[2]), 32'h78);
        check("f0_lit3", 32'(lit[3]), 32'd0);
        check("f0_seg3_carry", 32'(seg_end[3]), 32'hC0);
        check("f0_overlap", 32'(overlap), 32'd0);

        run_frame(12, 1, 32);
        check("f1_seg0_old", 32'(seg_lit[0]), 32'h92);
        check("f1_seg1", 32'(seg_lit[1]), 32'hA4);

        run_frame(-1, 0, 32);
        check("f2_lit0", 32'(lit[0]), 32'd6);
        check("f2_seg0_new", 32'(seg_lit[0]), 32'h82);

        run_frame(4, 2, 32);
        check("f3_tu_before", 32'(tu_hist[4]), 32'h0);
        check("f3_tu_set", 32'(tu_hist[5]), 32'h1);
        check("f3_lit0", 32'(lit[0]), 32'd6);
        check("f3_lit1", 32'(lit[1]), 32'd6);

        run_frame(-1, 0, 32);
        check("f4_lit0", 32'(lit[0]), 32'd6);
        check("f4_tu_hold", 32'(tu_hist[0]), 32'h1);

        run_frame(-1, 0, 32);
        check("f5_lit0", 32'(lit[0]), 32'd6);
        check("f5_lit1", 32'(lit[1]), 32'd6);

        run_frame(-1, 0, 32);
        check("f6_dark0", 32'(lit[0]), 32'd0);
        check("f6_dark1", 32'(lit[1]), 32'd0);
        check("f6_lit2", 32'(lit[2]), 32'd6);
        check("f6_seg2", 32'(seg_lit[2]), 32'h78);

        run_frame(4, 3, 32);
        check("f7_tu_before", 32'(tu_hist[4]), 32'h1);
        check("f7_tu_clr", 32'(tu_hist[5]), 32'h0);
        check("f7_lit0", 32'(lit[0]), 32'd1);
        check("f7_lit1", 32'(lit[1]), 32'd6);
        check("f7_lit2", 32'(lit[2]), 32'd6);

        run_frame(-1, 0, 32);
        check("f8_lit0", 32'(lit[0]), 32'd6);
        check("f8_lit1", 32'(lit[1]), 32'd6);
        check("f8_tu", 32'(tu_hist[31]), 32'h0);

        run_frame(-1, 0, 32);
        check("f9_lit0_steady", 32'(lit[0]), 32'd6);

        run_frame(4, 2, 32);
        check("f10_tu_set", 32'(tu_hist[5]), 32'h1);

        run_frame(4, 4, 32);
        check("f11_set_wins", 32'(tu_hist[5]), 32'h1);
        check("f11_tu_end", 32'(tu_hist[31]), 32'h1);
        check("f11_lit0", 32'(lit[0]), 32'd6);

        score_l = 4'd12;
        run_frame(-1, 0, 32);
        check("f12_lit0", 32'(lit[0]), 32'd6);
        check("f12_seg2_old", 32'(seg_lit[2]), 32'h78);

        run_frame(20, 5, 22);
        check("f13_dark0", 32'(lit[0]), 32'd0);
        check("f13_dark1", 32'(lit[1]), 32'd0);
        check("f13_lit2", 32'(lit[2]), 32'd3);
        check("f13_seg2_dash", 32'(seg_lit[2]), 32'h3F);
        check("f13_tu_pre_rst", 32'(tu_hist[20]), 32'h1);
        check("f13_rst_an", 32'(last_an), 32'hF);
        check("f13_rst_seg", 32'(last_seg), 32'hFF);
        check("f13_rst_tu", 32'(tu_hist[21]), 32'h0);

        run_frame(-1, 0, 32);
        check("f14_first_lit", 32'(first_lit), 32'd2);
        check("f14_lit0", 32'(lit[0]), 32'd6);
        check("f14_seg0", 32'(seg_lit[0]), 32'h82);
        check("f14_lit2", 32'(lit[2]), 32'd6);
        check("f14_seg2", 32'(seg_lit[2]), 32'h3F);
        check("f14_tu", 32'(tu_hist[31]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
